shift_sequencer: RTL
====================

// Module: shift_sequencer
// PURPOSE
//  Multi-cycle controller that drives the single-bit shift datapath of the DSP.
//  Accepts an operand, opcode and shift count; applies one 1-bit shift per clock.
//  Start/Ready/Done handshake toward the DSP control unit.
//  Leaves the combinational 1-bit shifters reusable for N-bit shifts without barrel logic.
// PARAMETERS
//  WIDTH  8  operand/result width in bits
//  CNT_W  4  shift-count width; counts 0..2^CNT_W-1 are accepted
// PORTS
//  Clk       in   1        system clock, all logic on rising edge
//  Reset     in   1        synchronous, active-high reset
//  Start     in   1        request; sampled only while Ready=1
//  Op        in   2        00 logical left, 01 logical right, 10 arithmetic right, 11 rotate left
//  Count     in   CNT_W    number of 1-bit shifts to apply
//  In1       in   WIDTH    operand
//  Ready     out  1        high in IDLE; block accepts Start
//  Busy      out  1        high in SHIFT
//  Done      out  1        one-cycle pulse; Out holds the new result
//  Out       out  WIDTH    result register; holds until next Done
//  Carry     out  1        last bit shifted out (SHIFT_FLAGS_EN only)
//  Zero      out  1        Out==0 (SHIFT_FLAGS_EN only)
// BEHAVIOUR
//  - Clock/reset: one clock (Clk); Reset is synchronous and active-high.
//  - Reset: state=IDLE; Out=0, Done=0, Busy=0, Ready=1, Carry=0, Zero=0.
//  - Reset has priority over all events, including mid-SHIFT. An aborted op produces no Done.
//  - FSM IDLE -> SHIFT -> DONE -> IDLE. Outputs decode from registered state only.
//  - IDLE: on Start, latch In1 into shift reg, Op into op reg, Count into cnt.
//      Next state is DONE if Count==0, else SHIFT.
//  - SHIFT: each edge shifts the shift reg by one bit per the latched Op and decrements cnt.
//      Leave for DONE on the edge where cnt==1.
//  - Shift ops (1 bit, WIDTH preserved):
//      LSL {s[W-2:0],0}; LSR {0,s[W-1:1]}; ASR {s[W-1],s[W-1:1]}; ROL {s[W-2:0],s[W-1]}.
//  - Out is loaded with the final shift-reg value on the edge entering DONE.
//  - DONE: Done=1 for exactly one cycle, then IDLE unconditionally.
//  - Latency: Start sampled at edge E0 -> Done high in the cycle after edge E(Count).
//      That is Count+1 cycles; Count=0 gives Done 1 cycle after Start with Out=In1.
//  - Start while Busy or in DONE: ignored, not queued. In1/Op/Count changes after E0 have no effect.
//  - Back-to-back: Start may be re-asserted the cycle after Done (Ready=1 again).
//  - Count >= WIDTH is legal and iterated literally:
//      LSL/LSR give 0; ASR gives all sign bits; ROL wraps modulo WIDTH.
//  - Out unchanged from Done until the next DONE entry; it is not cleared on Start.
// CONFIGURATION
//  - SHIFT_FLAGS_EN defined:
//      Carry = bit shifted out on the final shift step (LSL/ROL: old MSB; LSR/ASR: old LSB).
//      Carry=0 when Count==0. Zero=(final result==0).
//      Both update on the edge entering DONE, same as Out.
//  - SHIFT_FLAGS_EN undefined: Carry and Zero ports remain but are tied to 0; no flag logic.
// TESTING
//  1. Reset, then Op=00, Count=3, In1=8'h15, Start one cycle.
//       -> Busy for 3 cycles; Done in 4th cycle; Out=8'hA8; Carry=0 (flags on).
//  2. Op=10, Count=2, In1=8'h90 -> Out=8'hE4 after 3 cycles. Repeat with Op=01 -> Out=8'h24.
//  3. Op=11, Count=9, In1=8'h81 -> Out=8'h03 (wraps), Done 10 cycles after Start.
//       Then Op=00, Count=8, In1=8'hFF -> Out=8'h00, Zero=1.
//  4. Count=0, In1=8'h5A -> Done 1 cycle later, Out=8'h5A, Carry=0.
//       Pulse Start again while Busy in another op -> ignored, result unaffected.
//  5. Op=00, Count=6 started; Reset asserted on 3rd SHIFT cycle.
//       -> next cycle Ready=1, Out=0, no Done pulse.
//  6. Two ops back-to-back, second Start the cycle after Done -> both Done pulses occur.
//       Out matches the golden shift model; run with and without SHIFT_FLAGS_EN.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - control/data handshake bundle between the DSP control unit and the shift sequencer
interface shift_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             Start;
    logic [1:0]       Op;
    logic [CNT_W-1:0] Count;
    logic [WIDTH-1:0] In1;
    logic             Ready;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Out;
    logic             Carry;
    logic             Zero;

    modport master (
        output Start, Op, Count, In1,
        input  Ready, Busy, Done, Out, Carry, Zero
    );

    modport slave (
        input  Start, Op, Count, In1,
        output Ready, Busy, Done, Out, Carry, Zero
    );
endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle 1-bit-per-clock shift controller; SHIFT_FLAGS_EN enables Carry/Zero flags
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    shift_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] sh, sh_next, out_q;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt;
    logic             ready, busy, done;
    logic             count_zero, last_step;

    assign count_zero = (bus.Count == '0);
    assign last_step  = (cnt == CNT_W'(1));

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.Start) next_state = count_zero ? DONE : SHIFT;
            SHIFT:   if (last_step) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            IDLE:    ready = 1'b1;
            SHIFT:   busy  = 1'b1;
            DONE:    done  = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Single-bit shifter reused every SHIFT cycle instead of a barrel shifter
    always_comb begin
        sh_next = sh;
        case (op_q)
            2'b00: sh_next = {sh[WIDTH-2:0], 1'b0};
            2'b01: sh_next = {1'b0, sh[WIDTH-1:1]};
            2'b10: sh_next = {sh[WIDTH-1], sh[WIDTH-1:1]};
            2'b11: sh_next = {sh[WIDTH-2:0], sh[WIDTH-1]};
            default: sh_next = sh;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sh    <= '0;
            op_q  <= '0;
            cnt   <= '0;
            out_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.Start) begin
                    sh   <= bus.In1;
                    op_q <= bus.Op;
                    cnt  <= bus.Count;
                    if (count_zero) out_q <= bus.In1;
                end
                SHIFT: begin
                    sh  <= sh_next;
                    cnt <= cnt - CNT_W'(1);
                    if (last_step) out_q <= sh_next;
                end
                default: ;
            endcase
        end
    end

`ifdef SHIFT_FLAGS_EN
    logic carry_q, zero_q, shout;

    // LSL/ROL lose the MSB, LSR/ASR lose the LSB
    assign shout = (op_q == 2'b00 || op_q == 2'b11) ? sh[WIDTH-1] : sh[0];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.Start && count_zero) begin
                    carry_q <= 1'b0;
                    zero_q  <= (bus.In1 == '0);
                end
                SHIFT: if (last_step) begin
                    carry_q <= shout;
                    zero_q  <= (sh_next == '0);
                end
                default: ;
            endcase
        end
    end

    assign bus.Carry = carry_q;
    assign bus.Zero  = zero_q;
`else
    assign bus.Carry = 1'b0;
    assign bus.Zero  = 1'b0;
`endif

    assign bus.Ready = ready;
    assign bus.Busy  = busy;
    assign bus.Done  = done;
    assign bus.Out   = out_q;
endmodule
